// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
//   Bundle of every non-clock/reset signal between the decode stage and its
//   neighbours (IF/ID register, register file, write-back, EX stage).
//   master : the environment (IF/ID, regfile, WB, EX) driving the stage
//   slave  : the id_ex_stage itself
//   Inputs to the stage : if_valid, if_instr, if_pc, flush, rf_rd1, rf_rd2,
//                         wb_regwrite, wb_rd, wb_data
//   Outputs of the stage: rf_ra1, rf_ra2, id_stall, ex_valid, ex_cls, ex_pc,
//                         ex_opa, ex_opb, ex_imm, ex_rd, ex_regwrite
interface id_ex_stage_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        flush;

  logic [4:0]  rf_ra1;
  logic [4:0]  rf_ra2;
  logic [63:0] rf_rd1;
  logic [63:0] rf_rd2;

  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  logic        id_stall;

  logic        ex_valid;
  logic [2:0]  ex_cls;
  logic [63:0] ex_pc;
  logic [63:0] ex_opa;
  logic [63:0] ex_opb;
  logic [63:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;

  modport master (
    output if_valid, if_instr, if_pc, flush,
    output rf_rd1, rf_rd2,
    output wb_regwrite, wb_rd, wb_data,
    input  rf_ra1, rf_ra2, id_stall,
    input  ex_valid, ex_cls, ex_pc, ex_opa, ex_opb, ex_imm, ex_rd, ex_regwrite
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush,
    input  rf_rd1, rf_rd2,
    input  wb_regwrite, wb_rd, wb_data,
    output rf_ra1, rf_ra2, id_stall,
    output ex_valid, ex_cls, ex_pc, ex_opa, ex_opb, ex_imm, ex_rd, ex_regwrite
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Instruction decode for the LEGv8 subset plus the ID/EX pipeline register.
//   Drives register-file read addresses, bypasses same-cycle write-back data,
//   detects load-use hazards (one-cycle stall + bubble) and honours flushes.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous active-low reset (0 clears the ID/EX register)
//     bus   : id_ex_stage_if.slave -- IF/ID inputs, regfile read ports,
//             write-back bus, stall output and the registered ex_* outputs
module id_ex_stage (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_ADD  = 3'd1,
    CLS_SUB  = 3'd2,
    CLS_ADDI = 3'd3,
    CLS_LDUR = 3'd4,
    CLS_STUR = 3'd5,
    CLS_CBZ  = 3'd6,
    CLS_B    = 3'd7
  } cls_e;

  typedef struct packed {
    logic        valid;
    cls_e        cls;
    logic [63:0] pc;
    logic [63:0] opa;
    logic [63:0] opb;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        regwrite;
  } idex_t;

  localparam logic [4:0] XZR = 5'd31;

  logic [31:0] instr;
  cls_e        dec_cls;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        use1;
  logic        use2;
  logic [63:0] dec_imm;
  logic [63:0] opa;
  logic [63:0] opb;
  logic        dec_regwrite;
  logic        hazard;
  idex_t       ex_q;
  idex_t       ex_d;

  assign instr = bus.if_instr;

  // Decode: most specific opcode widths first so the first match wins.
  always_comb begin
    dec_cls = CLS_NOP;
    if (instr[31:21] == 11'h458)      dec_cls = CLS_ADD;
    else if (instr[31:21] == 11'h658) dec_cls = CLS_SUB;
    else if (instr[31:21] == 11'h7C2) dec_cls = CLS_LDUR;
    else if (instr[31:21] == 11'h7C0) dec_cls = CLS_STUR;
    else if (instr[31:22] == 10'h244) dec_cls = CLS_ADDI;
    else if (instr[31:24] == 8'hB4)   dec_cls = CLS_CBZ;
    else if (instr[31:26] == 6'h05)   dec_cls = CLS_B;
  end

  // Register addresses and which of them the instruction actually reads.
  // STUR/CBZ take their second source from the Rt field (Reg2Loc).
  always_comb begin
    ra1 = instr[9:5];
    ra2 = instr[20:16];
    use1 = 1'b0;
    use2 = 1'b0;
    unique case (dec_cls)
      CLS_ADD, CLS_SUB: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      CLS_ADDI, CLS_LDUR: begin
        use1 = 1'b1;
      end
      CLS_STUR: begin
        ra2  = instr[4:0];
        use1 = 1'b1;
        use2 = 1'b1;
      end
      CLS_CBZ: begin
        ra2  = instr[4:0];
        use2 = 1'b1;
      end
      default: begin
        use1 = 1'b0;
        use2 = 1'b0;
      end
    endcase
  end

  always_comb begin
    dec_imm = '0;
    unique case (dec_cls)
      CLS_ADDI:           dec_imm = {52'd0, instr[21:10]};
      CLS_LDUR, CLS_STUR: dec_imm = {{55{instr[20]}}, instr[20:12]};
      CLS_CBZ:            dec_imm = {{43{instr[23]}}, instr[23:5], 2'b00};
      CLS_B:              dec_imm = {{36{instr[25]}}, instr[25:0], 2'b00};
      default:            dec_imm = '0;
    endcase
  end

  // Operand fetch with write-back bypass; XZR reads zero and is never bypassed.
  always_comb begin
    if (ra1 == XZR)
      opa = '0;
    else if (bus.wb_regwrite && (bus.wb_rd == ra1))
      opa = bus.wb_data;
    else
      opa = bus.rf_rd1;

    if (ra2 == XZR)
      opb = '0;
    else if (bus.wb_regwrite && (bus.wb_rd == ra2))
      opb = bus.wb_data;
    else
      opb = bus.rf_rd2;
  end

  always_comb begin
    dec_regwrite = 1'b0;
    if ((dec_cls == CLS_ADD) || (dec_cls == CLS_SUB) ||
        (dec_cls == CLS_ADDI) || (dec_cls == CLS_LDUR))
      dec_regwrite = (instr[4:0] != XZR);
  end

  // Load-use: the load in EX cannot supply its data to a consumer in ID yet.
  always_comb begin
    hazard = 1'b0;
    if (ex_q.valid && (ex_q.cls == CLS_LDUR) && (ex_q.rd != XZR) &&
        bus.if_valid && !bus.flush) begin
      if ((use1 && (ra1 == ex_q.rd)) || (use2 && (ra2 == ex_q.rd)))
        hazard = 1'b1;
    end
  end

  always_comb begin
    ex_d          = '0;
    ex_d.valid    = bus.if_valid;
    ex_d.cls      = dec_cls;
    ex_d.pc       = bus.if_pc;
    ex_d.opa      = opa;
    ex_d.opb      = opb;
    ex_d.imm      = dec_imm;
    ex_d.rd       = instr[4:0];
    ex_d.regwrite = bus.if_valid && dec_regwrite;
  end

  // Flush and hazard both load an all-zero bubble; flush also suppresses
  // the stall through the !flush term in the hazard condition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ex_q <= '0;
    else if (bus.flush || hazard)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign bus.rf_ra1      = ra1;
  assign bus.rf_ra2      = ra2;
  assign bus.id_stall    = hazard;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_cls      = ex_q.cls;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_opa      = ex_q.opa;
  assign bus.ex_opb      = ex_q.opb;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_regwrite = ex_q.regwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic clk;
  logic reset;
  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        fl;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [63:0] wbd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        stall;
    logic        ev;
    logic [2:0]  cls;
    logic [63:0] opa;
    logic [63:0] opb;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        rw;
  } vec_t;

  typedef struct {
    logic        ev;
    logic [2:0]  cls;
    logic [63:0] pc;
    logic [63:0] opa;
    logic [63:0] opb;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  localparam logic [63:0] M8  = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] M16 = 64'hFFFF_FFFF_FFFF_FFF0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".ex_valid"},    64'(bus.ex_valid),    64'd0);
    chk({tag, ".ex_cls"},      64'(bus.ex_cls),      64'd0);
    chk({tag, ".ex_pc"},       bus.ex_pc,            64'd0);
    chk({tag, ".ex_opa"},      bus.ex_opa,           64'd0);
    chk({tag, ".ex_opb"},      bus.ex_opb,           64'd0);
    chk({tag, ".ex_imm"},      bus.ex_imm,           64'd0);
    chk({tag, ".ex_rd"},       64'(bus.ex_rd),       64'd0);
    chk({tag, ".ex_regwrite"}, 64'(bus.ex_regwrite), 64'd0);
    chk({tag, ".id_stall"},    64'(bus.id_stall),    64'd0);
  endtask

  task automatic drive(input vec_t t);
    bus.if_valid    = t.v;
    bus.if_instr    = t.instr;
    bus.if_pc       = t.pc;
    bus.flush       = t.fl;
    bus.rf_rd1      = t.rd1;
    bus.rf_rd2      = t.rd2;
    bus.wb_regwrite = t.wbw;
    bus.wb_rd       = t.wbrd;
    bus.wb_data     = t.wbd;
  endtask

  task automatic drive_random();
    bus.if_valid    = 1'b1;
    bus.if_instr    = $urandom;
    bus.if_pc       = {$urandom, $urandom};
    bus.flush       = 1'($urandom_range(0, 1));
    bus.rf_rd1      = {$urandom, $urandom};
    bus.rf_rd2      = {$urandom, $urandom};
    bus.wb_regwrite = 1'($urandom_range(0, 1));
    bus.wb_rd       = 5'($urandom_range(0, 31));
    bus.wb_data     = {$urandom, $urandom};
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic apply(input vec_t t, input string tag);
    exp_t e;
    exp_t got;
    drive(t);
    #2;
    chk({tag, ".rf_ra1"},   64'(bus.rf_ra1),   64'(t.ra1));
    chk({tag, ".rf_ra2"},   64'(bus.rf_ra2),   64'(t.ra2));
    chk({tag, ".id_stall"}, 64'(bus.id_stall), 64'(t.stall));
    e.ev  = t.ev;
    e.cls = t.cls;
    e.pc  = (t.stall || t.fl) ? 64'd0 : t.pc;
    e.opa = t.opa;
    e.opb = t.opb;
    e.imm = t.imm;
    e.rd  = t.rd;
    e.rw  = t.rw;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s.scoreboard: got empty queue expected an entry", tag);
    end else begin
      n_checks--;
      got = sb.pop_front();
      chk({tag, ".ex_valid"},    64'(bus.ex_valid),    64'(got.ev));
      chk({tag, ".ex_cls"},      64'(bus.ex_cls),      64'(got.cls));
      chk({tag, ".ex_pc"},       bus.ex_pc,            got.pc);
      chk({tag, ".ex_opa"},      bus.ex_opa,           got.opa);
      chk({tag, ".ex_opb"},      bus.ex_opb,           got.opb);
      chk({tag, ".ex_imm"},      bus.ex_imm,           got.imm);
      chk({tag, ".ex_rd"},       64'(bus.ex_rd),       64'(got.rd));
      chk({tag, ".ex_regwrite"}, 64'(bus.ex_regwrite), 64'(got.rw));
    end
  endtask

  vec_t tbl[32];
  int unsigned n_tbl;
  vec_t r_ldur;
  vec_t r_dep;
  vec_t r_add;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    //           v     instr          pc        fl    rd1        rd2       wbw   wbrd   wbd          ra1    ra2    stl   ev    cls   opa        opb         imm     rd     rw
    tbl[0]  = '{1'b1, 32'h8B030041, 64'h100, 1'b0, 64'd5,     64'd7,    1'b0, 5'd0,  64'h0,    5'd2,  5'd3,  1'b0, 1'b1, 3'd1, 64'd5,     64'd7,     64'd0,  5'd1,  1'b1};
    tbl[1]  = '{1'b1, 32'h91004024, 64'h104, 1'b0, 64'd0,     64'h55,   1'b1, 5'd1,  64'h99,   5'd1,  5'd0,  1'b0, 1'b1, 3'd3, 64'h99,    64'h55,    64'd16, 5'd4,  1'b1};
    tbl[2]  = '{1'b1, 32'h910043E4, 64'h108, 1'b0, 64'd0,     64'd0,    1'b1, 5'd31, 64'h99,   5'd31, 5'd0,  1'b0, 1'b1, 3'd3, 64'd0,     64'd0,     64'd16, 5'd4,  1'b1};
    tbl[3]  = '{1'b1, 32'hF8408002, 64'h10C, 1'b0, 64'h1000,  64'h22,   1'b0, 5'd0,  64'h0,    5'd0,  5'd0,  1'b0, 1'b1, 3'd4, 64'h1000,  64'h22,    64'd8,  5'd2,  1'b1};
    tbl[4]  = '{1'b1, 32'h8B030045, 64'h110, 1'b0, 64'hAA,    64'hBB,   1'b0, 5'd0,  64'h0,    5'd2,  5'd3,  1'b1, 1'b0, 3'd0, 64'd0,     64'd0,     64'd0,  5'd0,  1'b0};
    tbl[5]  = '{1'b1, 32'h8B030045, 64'h110, 1'b0, 64'hAA,    64'hBB,   1'b0, 5'd0,  64'h0,    5'd2,  5'd3,  1'b0, 1'b1, 3'd1, 64'hAA,    64'hBB,    64'd0,  5'd5,  1'b1};
    tbl[6]  = '{1'b1, 32'h8B0700C5, 64'h114, 1'b0, 64'd1,     64'd2,    1'b0, 5'd0,  64'h0,    5'd6,  5'd7,  1'b0, 1'b1, 3'd1, 64'd1,     64'd2,     64'd0,  5'd5,  1'b1};
    tbl[7]  = '{1'b1, 32'hF81F8022, 64'h118, 1'b0, 64'h2000,  64'h77,   1'b0, 5'd0,  64'h0,    5'd1,  5'd2,  1'b0, 1'b1, 3'd5, 64'h2000,  64'h77,    M8,     5'd2,  1'b0};
    tbl[8]  = '{1'b1, 32'hB4FFFF83, 64'h11C, 1'b0, 64'd5,     64'd0,    1'b0, 5'd0,  64'h0,    5'd28, 5'd3,  1'b0, 1'b1, 3'd6, 64'd5,     64'd0,     M16,    5'd3,  1'b0};
    tbl[9]  = '{1'b1, 32'h14000001, 64'h120, 1'b0, 64'd0,     64'd0,    1'b0, 5'd0,  64'h0,    5'd0,  5'd0,  1'b0, 1'b1, 3'd7, 64'd0,     64'd0,     64'd4,  5'd1,  1'b0};
    tbl[10] = '{1'b1, 32'h00000000, 64'h124, 1'b0, 64'h11,    64'h22,   1'b0, 5'd0,  64'h0,    5'd0,  5'd0,  1'b0, 1'b1, 3'd0, 64'h11,    64'h22,    64'd0,  5'd0,  1'b0};
    tbl[11] = '{1'b1, 32'h8B03005F, 64'h128, 1'b0, 64'd3,     64'd4,    1'b0, 5'd0,  64'h0,    5'd2,  5'd3,  1'b0, 1'b1, 3'd1, 64'd3,     64'd4,     64'd0,  5'd31, 1'b0};
    tbl[12] = '{1'b1, 32'hCB0B0149, 64'h12C, 1'b0, 64'd100,   64'd30,   1'b1, 5'd11, 64'h1234, 5'd10, 5'd11, 1'b0, 1'b1, 3'd2, 64'd100,   64'h1234,  64'd0,  5'd9,  1'b1};
    tbl[13] = '{1'b0, 32'h8B030041, 64'h130, 1'b0, 64'd5,     64'd7,    1'b0, 5'd0,  64'h0,    5'd2,  5'd3,  1'b0, 1'b0, 3'd1, 64'd5,     64'd7,     64'd0,  5'd1,  1'b0};
    tbl[14] = '{1'b1, 32'hF840801F, 64'h134, 1'b0, 64'd1,     64'd2,    1'b0, 5'd0,  64'h0,    5'd0,  5'd0,  1'b0, 1'b1, 3'd4, 64'd1,     64'd2,     64'd8,  5'd31, 1'b0};
    tbl[15] = '{1'b1, 32'h8B0303E5, 64'h138, 1'b0, 64'd9,     64'd8,    1'b0, 5'd0,  64'h0,    5'd31, 5'd3,  1'b0, 1'b1, 3'd1, 64'd0,     64'd8,     64'd0,  5'd5,  1'b1};
    tbl[16] = '{1'b1, 32'hF8400023, 64'h13C, 1'b0, 64'h40,    64'd0,    1'b0, 5'd0,  64'h0,    5'd1,  5'd0,  1'b0, 1'b1, 3'd4, 64'h40,    64'd0,     64'd0,  5'd3,  1'b1};
    tbl[17] = '{1'b1, 32'hB4FFFF83, 64'h140, 1'b0, 64'd0,     64'd5,    1'b0, 5'd0,  64'h0,    5'd28, 5'd3,  1'b1, 1'b0, 3'd0, 64'd0,     64'd0,     64'd0,  5'd0,  1'b0};
    tbl[18] = '{1'b1, 32'hB4FFFF83, 64'h140, 1'b0, 64'd0,     64'd5,    1'b0, 5'd0,  64'h0,    5'd28, 5'd3,  1'b0, 1'b1, 3'd6, 64'd0,     64'd5,     M16,    5'd3,  1'b0};
    tbl[19] = '{1'b0, 32'hF8400026, 64'h144, 1'b0, 64'h40,    64'd0,    1'b0, 5'd0,  64'h0,    5'd1,  5'd0,  1'b0, 1'b0, 3'd4, 64'h40,    64'd0,     64'd0,  5'd6,  1'b0};
    tbl[20] = '{1'b1, 32'h8B0700C5, 64'h148, 1'b0, 64'd1,     64'd2,    1'b0, 5'd0,  64'h0,    5'd6,  5'd7,  1'b0, 1'b1, 3'd1, 64'd1,     64'd2,     64'd0,  5'd5,  1'b1};
    tbl[21] = '{1'b1, 32'hF8408002, 64'h14C, 1'b0, 64'd0,     64'd0,    1'b0, 5'd0,  64'h0,    5'd0,  5'd0,  1'b0, 1'b1, 3'd4, 64'd0,     64'd0,     64'd8,  5'd2,  1'b1};
    tbl[22] = '{1'b1, 32'hF81F8022, 64'h150, 1'b0, 64'h2000,  64'h77,   1'b0, 5'd0,  64'h0,    5'd1,  5'd2,  1'b1, 1'b0, 3'd0, 64'd0,     64'd0,     64'd0,  5'd0,  1'b0};
    tbl[23] = '{1'b1, 32'hF81F8022, 64'h150, 1'b0, 64'h2000,  64'h77,   1'b0, 5'd0,  64'h0,    5'd1,  5'd2,  1'b0, 1'b1, 3'd5, 64'h2000,  64'h77,    M8,     5'd2,  1'b0};
    // flush priority over a live load-use hazard, then flush of a plain op
    tbl[24] = '{1'b1, 32'hF8408002, 64'h200, 1'b0, 64'd0,     64'd0,    1'b0, 5'd0,  64'h0,    5'd0,  5'd0,  1'b0, 1'b1, 3'd4, 64'd0,     64'd0,     64'd8,  5'd2,  1'b1};
    tbl[25] = '{1'b1, 32'h8B030045, 64'h204, 1'b1, 64'hAA,    64'hBB,   1'b0, 5'd0,  64'h0,    5'd2,  5'd3,  1'b0, 1'b0, 3'd0, 64'd0,     64'd0,     64'd0,  5'd0,  1'b0};
    tbl[26] = '{1'b1, 32'h8B030041, 64'h208, 1'b1, 64'd5,     64'd7,    1'b0, 5'd0,  64'h0,    5'd2,  5'd3,  1'b0, 1'b0, 3'd0, 64'd0,     64'd0,     64'd0,  5'd0,  1'b0};
    tbl[27] = '{1'b1, 32'h14000001, 64'h20C, 1'b0, 64'd0,     64'd0,    1'b0, 5'd0,  64'h0,    5'd0,  5'd0,  1'b0, 1'b1, 3'd7, 64'd0,     64'd0,     64'd4,  5'd1,  1'b0};
    // back-to-back dependent loads: one stall, then the second load issues
    tbl[28] = '{1'b1, 32'hF8408002, 64'h300, 1'b0, 64'd0,     64'd0,    1'b0, 5'd0,  64'h0,    5'd0,  5'd0,  1'b0, 1'b1, 3'd4, 64'd0,     64'd0,     64'd8,  5'd2,  1'b1};
    tbl[29] = '{1'b1, 32'hF8400043, 64'h304, 1'b0, 64'h500,   64'd0,    1'b0, 5'd0,  64'h0,    5'd2,  5'd0,  1'b1, 1'b0, 3'd0, 64'd0,     64'd0,     64'd0,  5'd0,  1'b0};
    tbl[30] = '{1'b1, 32'hF8400043, 64'h304, 1'b0, 64'h500,   64'd0,    1'b0, 5'd0,  64'h0,    5'd2,  5'd0,  1'b0, 1'b1, 3'd4, 64'h500,   64'd0,     64'd0,  5'd3,  1'b1};
    tbl[31] = '{1'b1, 32'h8B0700C5, 64'h308, 1'b0, 64'd1,     64'd2,    1'b0, 5'd0,  64'h0,    5'd6,  5'd7,  1'b0, 1'b1, 3'd1, 64'd1,     64'd2,     64'd0,  5'd5,  1'b1};
    n_tbl = 32;

    r_ldur = tbl[3];
    r_dep  = tbl[4];
    r_add  = tbl[0];

    // Reset held with random inputs: everything reads zero.
    reset = 1'b0;
    drive_random();
    #2;
    check_zero("reset_init");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      drive_random();
      #2;
      check_zero("reset_hold");
    end
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int unsigned i = 0; i < n_tbl; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a stall drops the bubble; next edge loads normally.
    apply(r_ldur, "rst_ldur");
    drive(r_dep);
    #2;
    chk("rst_pre_stall", 64'(bus.id_stall), 64'd1);
    reset = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_edge");
    reset = 1'b1;
    apply(r_add, "rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
